// File: rtl/sdpram_burst_reader.sv
// Burst read engine for a simple dual-port RAM: issues sequential reads against a
// fixed read latency and replays the returned words as a valid/ready stream.
module sdpram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_clk_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = FCW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      len_q, issued_q, pushed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addr_vld_q;
  logic [RD_LATENCY-1:0] tag_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic                  fifo_last_d [FIFO_DEPTH];
  logic [FCW-1:0]        count_q, count_d, wr_idx_c;

  logic             issue_c, push_c, pop_c, accept_c, zero_cmd_c, finish_c, push_last_c;
  logic [SUM_W-1:0] in_flight_c, credit_c;

  assign pop_c       = m_valid & m_ready;
  assign push_c      = tag_q[RD_LATENCY-1];
  assign push_last_c = (pushed_q + CNT_W'(1)) == len_q;
  assign m_data      = fifo_data_q[0];

  // Occupancy committed to the FIFO: reads in the address stage and RAM pipe,
  // plus stored words net of this cycle's pop.
  always_comb begin
    in_flight_c = SUM_W'(addr_vld_q);
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      in_flight_c = in_flight_c + SUM_W'(tag_q[i]);
    end
    credit_c = SUM_W'(count_q) - SUM_W'(pop_c) + in_flight_c;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    zero_cmd_c = 1'b0;
    issue_c    = 1'b0;
    finish_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept_c = 1'b1;
            state_d  = S_READ;
          end else begin
            zero_cmd_c = 1'b1;
          end
        end
      end
      S_READ: begin
        issue_c = (issued_q < len_q) && (credit_c < SUM_W'(FIFO_DEPTH));
        if (issue_c && ((issued_q + CNT_W'(1)) == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop_c && m_last) begin
          finish_c = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-register FIFO: the head is always entry 0, so stream outputs are flops.
  always_comb begin
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      fifo_data_d[i] = fifo_data_q[i];
      fifo_last_d[i] = fifo_last_q[i];
    end
    if (pop_c) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        fifo_data_d[i] = fifo_data_q[i+1];
        fifo_last_d[i] = fifo_last_q[i+1];
      end
    end
    wr_idx_c = count_q - FCW'(pop_c);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (push_c && (FCW'(i) == wr_idx_c)) begin
        fifo_data_d[i] = ram_rd_data;
        fifo_last_d[i] = push_last_c;
      end
    end
    count_d = count_q + FCW'(push_c) - FCW'(pop_c);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_rd_addr   <= '0;
      ram_rd_clk_en <= 1'b0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      len_q         <= '0;
      issued_q      <= '0;
      pushed_q      <= '0;
      addr_q        <= '0;
      addr_vld_q    <= 1'b0;
      tag_q         <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      done <= finish_c | zero_cmd_c;
      if (accept_c) begin
        busy          <= 1'b1;
        ram_rd_clk_en <= 1'b1;
        addr_q        <= start_addr;
        len_q         <= length;
        issued_q      <= '0;
        pushed_q      <= '0;
      end else if (finish_c) begin
        busy          <= 1'b0;
        ram_rd_clk_en <= 1'b0;
      end
      if (issue_c) begin
        ram_rd_addr <= addr_q;
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        issued_q    <= issued_q + CNT_W'(1);
      end
      if (push_c) pushed_q <= pushed_q + CNT_W'(1);
      // Tag follows the address register through the RAM read pipeline.
      addr_vld_q <= issue_c;
      tag_q      <= RD_LATENCY'({tag_q, addr_vld_q});
      count_q    <= count_d;
      m_valid    <= count_d != '0;
      m_last     <= (count_d != '0) && fifo_last_d[0];
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_last_q[i] <= fifo_last_d[i];
      end
    end
  end

  no_fifo_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(push_c && !pop_c && (count_q == FCW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sdpram_burst_reader.sv
// Scoreboard bench: two readers (read latency 1 and 2) share stimulus; each lane
// has its own RAM model, expected-beat queue and output monitor.
module tb_sdpram_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] start_addr = '0;
  logic [9:0] length = '0;
  logic       m_ready = 1'b1;
  bit         rand_ready = 1'b0;

  logic [7:0] mem [512];
  logic [8:0] exp_mem [2][1024];
  int         wr_ptr [2];
  int         rd_ptr [2];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    logic       busy, done, ram_rd_clk_en, m_valid, m_last;
    logic [8:0] ram_rd_addr;
    logic [7:0] ram_rd_data, m_data, ram_q1, ram_q2;

    sdpram_burst_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .RD_LATENCY(g + 1), .FIFO_DEPTH(4)) dut (
      .rd_clk(clk), .rd_rst(rst), .start(start), .start_addr(start_addr), .length(length),
      .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr), .ram_rd_clk_en(ram_rd_clk_en),
      .ram_rd_data(ram_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last)
    );

    // RAM model: registered read, optional output register
    always @(posedge clk) begin
      if (ram_rd_clk_en) begin
        ram_q1 <= mem[ram_rd_addr];
        ram_q2 <= ram_q1;
      end
    end
    assign ram_rd_data = (g == 0) ? ram_q1 : ram_q2;

    int         cyc = 0, lat_cnt = 0, beats = 0, first_cyc = 0, last_cyc = 0;
    bit         lat_armed = 1'b0, exp_done_nxt = 1'b0, hold = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;
    logic [8:0] e;

    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        rd_ptr[g]    = wr_ptr[g];
        exp_done_nxt = 1'b0;
        hold         = 1'b0;
        lat_armed    = 1'b0;
      end else begin
        check($sformatf("done_l%0d", g + 1), 32'(done), 32'(exp_done_nxt));
        exp_done_nxt = 1'b0;
        if (hold) check($sformatf("stall_stable_l%0d", g + 1), {m_valid, m_last, m_data}, {1'b1, hold_l, hold_d});
        if (lat_armed) begin
          lat_cnt++;
          if (m_valid) begin
            check($sformatf("first_valid_latency_l%0d", g + 1), lat_cnt, 32'(4 + g));
            lat_armed = 1'b0;
          end
        end
        if (m_valid && m_ready) begin
          if (rd_ptr[g] == wr_ptr[g]) begin
            check($sformatf("unexpected_beat_l%0d", g + 1), 1, 0);
          end else begin
            e = exp_mem[g][rd_ptr[g] % 1024];
            check($sformatf("m_data_l%0d", g + 1), 32'(m_data), 32'(e[7:0]));
            check($sformatf("m_last_l%0d", g + 1), 32'(m_last), 32'(e[8]));
            exp_done_nxt = e[8];
            rd_ptr[g]++;
          end
          if (beats == 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
        end
        hold   = m_valid && !m_ready;
        hold_d = m_data;
        hold_l = m_last;
        if (start && !busy) begin
          if (length == '0) exp_done_nxt = 1'b1;
          else begin
            lat_armed = 1'b1;
            lat_cnt   = 0;
            beats     = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Push expected beats for both lanes, then strobe start for one cycle.
  task automatic cmd(input int addr, input int len);
    logic [8:0] a9;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < len; i++) begin
        a9 = 9'(addr + i);
        exp_mem[g][wr_ptr[g] % 1024] = {(i == len - 1), 8'hFF - a9[7:0]};
        wr_ptr[g]++;
      end
    end
    start_addr = 9'(addr);
    length     = 10'(len);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (n < budget && !(lane[0].busy == 1'b0 && lane[1].busy == 1'b0 &&
                           rd_ptr[0] == wr_ptr[0] && rd_ptr[1] == wr_ptr[1])) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_l1"}, {lane[0].busy, lane[0].done, lane[0].ram_rd_clk_en, lane[0].m_valid,
                          lane[0].m_last, lane[0].ram_rd_addr, lane[0].m_data}, 0);
    check({name, "_l2"}, {lane[1].busy, lane[1].done, lane[1].ram_rd_clk_en, lane[1].m_valid,
                          lane[1].m_last, lane[1].ram_rd_addr, lane[1].m_data}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int a = 0; a < 512; a++) mem[a] = 8'hFF - 8'(a);
    wr_ptr[0] = 0; wr_ptr[1] = 0; rd_ptr[0] = 0; rd_ptr[1] = 0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-array sweep at full rate
    cmd(0, 512);
    wait_drained(2000);
    check("throughput_l1", lane[0].last_cyc - lane[0].first_cyc, 511);
    check("throughput_l2", lane[1].last_cyc - lane[1].first_cyc, 511);
    check("beats_full_l1", lane[0].beats, 512);

    // Address wrap
    cmd(510, 4);
    wait_drained(100);

    // Random backpressure
    rand_ready = 1'b1;
    cmd(100, 64);
    wait_drained(2000);
    rand_ready = 1'b0;
    m_ready    = 1'b1;

    // Zero length: done only
    cmd(0, 0);
    wait_drained(50);

    // Start while busy is ignored
    cmd(20, 8);
    @(posedge clk); #1;
    start_addr = 9'd300;
    length     = 10'd5;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    wait_drained(200);
    check("ignored_start_beats_l1", lane[0].beats, 8);
    check("ignored_start_beats_l2", lane[1].beats, 8);

    // Asynchronous reset mid-burst
    cmd(0, 64);
    n = 0;
    while (lane[0].beats < 10 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_10_beats", 32'(n < 500), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cmd(5, 3);
    wait_drained(100);
    check("post_reset_beats_l1", lane[0].beats, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
